cfg_bus_master: RTL and testbench

CFG_BUS_MASTER -- requirements
Module: cfg_bus_master

---
 rtl/cfg_bus_master_if.sv | 39 +++
 rtl/cfg_bus_master.sv | 113 +++++++++++
 tb/tb_cfg_bus_master.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cfg_bus_master_if.sv
// Config bus master handshake bundle: host command/response channels plus the
// register bus toward the responder. The master modport is the bus master's view.
interface cfg_bus_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);

  // Host command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  // Host response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // Register bus toward the responder
  logic                  cs_n;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  resp;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rd_data, resp,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, cs_n, wr_en, addr, wr_data
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rd_data, resp,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, cs_n, wr_en, addr, wr_data
  );

endinterface

// File: rtl/cfg_bus_master.sv
// Config bus master: turns one host command into a single-cycle chip-select
// access, waits (bounded) for read data, and holds the result until consumed.
module cfg_bus_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic              clk,
  input logic              rst_n,
  cfg_bus_master_if.master bus
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  // Counter value on the WAIT cycle that would otherwise hit TIMEOUT
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e                state_q;
  logic [7:0]            cnt_q;
  logic                  cs_n_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  // Transaction FSM with all bus and response outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cs_n_q      <= 1'b1;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // cmd_ready is implied here: IDLE and out of reset
          if (bus.cmd_valid) begin
            state_q   <= StIssue;
            addr_q    <= bus.cmd_addr;
            wr_en_q   <= bus.cmd_wr;
            wr_data_q <= bus.cmd_wr ? bus.cmd_wdata : '0;
            cs_n_q    <= 1'b0;
          end
        end
        StIssue: begin
          cs_n_q  <= 1'b1;
          wr_en_q <= 1'b0;
          if (wr_en_q) begin
            // Writes complete on the strobe cycle itself
            state_q     <= StDone;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ~bus.resp;
            rsp_rdata_q <= '0;
          end else begin
            state_q <= StWait;
            cnt_q   <= '0;
          end
        end
        StWait: begin
          if (bus.resp) begin
            // A response on the final WAIT cycle still counts as success
            state_q     <= StDone;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= bus.rd_data;
          end else if (cnt_q == TimeoutLast) begin
            state_q     <= StDone;
            cnt_q       <= cnt_q + 8'd1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          if (bus.rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Drive the interface from the registered state
  always_comb begin
    bus.cmd_ready = (state_q == StIdle) && rst_n;
    bus.cs_n      = cs_n_q;
    bus.wr_en     = wr_en_q;
    bus.addr      = addr_q;
    bus.wr_data   = wr_data_q;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_rdata = rsp_rdata_q;
    bus.rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_cfg_bus_master.sv
// Self-checking bench for cfg_bus_master: directed and random transactions
// compared against a latency/result model derived from the transaction rules.
module tb_cfg_bus_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int          TO = 15;

  logic clk;
  logic rst_n;

  int n_cmp = 0;
  int n_bad = 0;

  cfg_bus_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

  cfg_bus_master #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cs_n"},      32'(bif.cs_n),      32'd1);
    chk({tag, "_wr_en"},     32'(bif.wr_en),     32'd0);
    chk({tag, "_addr"},      32'(bif.addr),      32'd0);
    chk({tag, "_wr_data"},   bif.wr_data,        32'd0);
    chk({tag, "_rsp_valid"}, 32'(bif.rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, bif.rsp_rdata,      32'd0);
    chk({tag, "_rsp_err"},   32'(bif.rsp_err),   32'd0);
  endtask

  // One full transaction, called at a negedge with the DUT in IDLE.
  // d = WAIT cycle (1-based) on which the responder answers a read; 0 = never.
  task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input bit wresp, input int d, input logic [DW-1:0] rd, input int bp);
    int            lat;
    bit            rd_ok;
    bit            exp_err;
    logic [DW-1:0] exp_rdata;
    rd_ok     = (d >= 1) && (d <= TO);
    lat       = wr ? 2 : (rd_ok ? 2 + d : 2 + TO);
    exp_err   = wr ? !wresp : !rd_ok;
    exp_rdata = (!wr && rd_ok) ? rd : '0;

    chk("idle_cmd_ready", 32'(bif.cmd_ready), 32'd1);
    bif.cmd_valid = 1'b1;
    bif.cmd_wr    = wr;
    bif.cmd_addr  = a;
    bif.cmd_wdata = wd;
    bif.rsp_ready = 1'b0;
    bif.resp      = 1'b0;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    bif.cmd_wr    = 1'($urandom);
    bif.cmd_addr  = AW'($urandom);
    bif.cmd_wdata = $urandom;

    for (int c = 1; c <= lat; c++) begin
      chk("cs_n", 32'(bif.cs_n), (c == 1) ? 32'd0 : 32'd1);
      chk("rsp_valid_timing", 32'(bif.rsp_valid), (c == lat) ? 32'd1 : 32'd0);
      chk("busy_cmd_ready", 32'(bif.cmd_ready), 32'd0);
      if (c == 1) begin
        chk("issue_addr", 32'(bif.addr), 32'(a));
        chk("issue_wr_en", 32'(bif.wr_en), 32'(wr));
        chk("issue_wr_data", bif.wr_data, wr ? wd : 32'd0);
      end else if (c < lat) begin
        chk("wait_wr_en", 32'(bif.wr_en), 32'd0);
      end
      if (wr) begin
        bif.resp = (c == 1) ? wresp : 1'($urandom);
      end else begin
        bif.resp = (d >= 1) && (c == 1 + d);
      end
      bif.rd_data = (!wr && c == 1 + d) ? rd : $urandom;
      if (c < lat) @(negedge clk);
    end

    chk("rsp_rdata", bif.rsp_rdata, exp_rdata);
    chk("rsp_err", 32'(bif.rsp_err), 32'(exp_err));

    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      bif.resp    = 1'($urandom);
      bif.rd_data = $urandom;
      chk("bp_rsp_valid", 32'(bif.rsp_valid), 32'd1);
      chk("bp_rsp_rdata", bif.rsp_rdata, exp_rdata);
      chk("bp_rsp_err", 32'(bif.rsp_err), 32'(exp_err));
      chk("bp_cs_n", 32'(bif.cs_n), 32'd1);
      chk("bp_cmd_ready", 32'(bif.cmd_ready), 32'd0);
    end

    // Consume, while offering a command that must not be taken this cycle
    @(negedge clk);
    bif.rsp_ready = 1'b1;
    bif.cmd_valid = 1'b1;
    bif.resp      = 1'b0;
    @(negedge clk);
    bif.rsp_ready = 1'b0;
    bif.cmd_valid = 1'b0;
    chk("post_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(bif.cmd_ready), 32'd1);
    chk("post_cs_n", 32'(bif.cs_n), 32'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bif.cmd_valid = 1'b0;
    bif.cmd_wr    = 1'b0;
    bif.cmd_addr  = '0;
    bif.cmd_wdata = '0;
    bif.rsp_ready = 1'b0;
    bif.rd_data   = '0;
    bif.resp      = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    chk("reset_cmd_ready", 32'(bif.cmd_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    txn(1'b1, 5'd3,  32'hA5A5_0001, 1'b1, 0,  32'h0,          0);
    txn(1'b1, 5'd30, 32'h1234_5678, 1'b0, 0,  32'h0,          0);
    txn(1'b0, 5'd3,  32'hDEAD_BEEF, 1'b0, 1,  32'hA5A5_0001,  0);
    txn(1'b0, 5'd9,  32'h0,         1'b0, 0,  32'hFFFF_FFFF,  0);
    txn(1'b0, 5'd9,  32'h0,         1'b0, TO, 32'h5A5A_F00D,  0);
    txn(1'b0, 5'd4,  32'h0,         1'b0, 2,  32'hC0DE_0042,  5);
    txn(1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 0,  32'h0,          5);

    // Reset in the middle of a pending read
    bif.cmd_valid = 1'b1;
    bif.cmd_wr    = 1'b0;
    bif.cmd_addr  = 5'd7;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midwait_cs_n", 32'(bif.cs_n), 32'd1);
    chk("midwait_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    rst_n       = 1'b0;
    bif.resp    = 1'b1;
    bif.rd_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_reset_values("midwait_rst");
    chk("midwait_rst_cmd_ready", 32'(bif.cmd_ready), 32'd0);
    rst_n    = 1'b1;
    bif.resp = 1'b0;
    @(negedge clk);
    chk("midwait_after_cmd_ready", 32'(bif.cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      bif.resp = 1'($urandom);
      @(negedge clk);
      chk("midwait_no_rsp", 32'(bif.rsp_valid), 32'd0);
    end
    bif.resp = 1'b0;

    // Random transactions with idle gaps
    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        bif.resp = 1'($urandom);
        @(negedge clk);
        chk("gap_cs_n", 32'(bif.cs_n), 32'd1);
        chk("gap_rsp_valid", 32'(bif.rsp_valid), 32'd0);
      end
      bif.resp = 1'b0;
      txn(1'($urandom), AW'($urandom), $urandom, 1'($urandom),
          int'($urandom_range(0, TO + 1)), $urandom, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
